// File: rtl/ulpi_reg_arbiter_pkg.sv
// ulpi_pkg: shared ULPI definitions for the register-access arbiter.
//   - ULPI register address/data widths
//   - frequently used ULPI register addresses
//   - arbiter FSM state encoding
package ulpi_pkg;

  localparam int unsigned ULPI_ADDR_W = 6;
  localparam int unsigned ULPI_DATA_W = 8;

  localparam logic [ULPI_ADDR_W-1:0] ULPI_FUN_CTRL = 6'h04;
  localparam logic [ULPI_ADDR_W-1:0] ULPI_OTG_CTRL = 6'h0A;
  localparam logic [ULPI_ADDR_W-1:0] ULPI_SCRATCH  = 6'h16;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RETRY,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/ulpi_reg_arbiter_rr_arbiter.sv
// rr_arbiter: N-way round-robin pick.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector
//   adv_i         : advance pointer past adv_idx_i (pulse when a transaction finishes)
//   adv_idx_i     : index of the requester just served
//   valid_o       : at least one request set
//   idx_o         : first set request at or after the pointer (wrapping)
module rr_arbiter #(
  parameter  int unsigned N_REQ = 3,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             adv_i,
  input  logic [IDX_W-1:0] adv_idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int unsigned      cand;
  logic             found;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (adv_idx_i == IDX_W'(N_REQ - 1)) ? '0 : adv_idx_i + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = (int'(ptr_q) + off) % N_REQ;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = IDX_W'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// ulpi_reg_arbiter: shares the ULPI register-access port between N_REQ requesters.
// Round-robin grant, one transaction in flight, bounded retry on REG_FAIL, watchdog timeout.
//   CLK_60M, NRST_A_USB          : clock, asynchronous active-low reset
//   REQ/REQ_RW/REQ_ADDR/REQ_WDATA: per-requester request, direction, address, write data
//   GNT, RSP_DONE, RSP_FAIL      : one-hot grant, completion / failure pulses
//   RSP_RDATA                    : read data, valid with RSP_DONE, held until next read
//   READY                        : ULPI core able to accept a register access
//   REG_EN/RW/ADDR/DATA_I        : issue strobe and transaction to the ULPI core
//   REG_DATA_O/REG_DONE/REG_FAIL : read data and completion status from the ULPI core
module ulpi_reg_arbiter
  import ulpi_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                         CLK_60M,
  input  logic                         NRST_A_USB,
  input  logic [N_REQ-1:0]             REQ,
  input  logic [N_REQ-1:0]             REQ_RW,
  input  logic [ULPI_ADDR_W*N_REQ-1:0] REQ_ADDR,
  input  logic [ULPI_DATA_W*N_REQ-1:0] REQ_WDATA,
  output logic [N_REQ-1:0]             GNT,
  output logic [N_REQ-1:0]             RSP_DONE,
  output logic [N_REQ-1:0]             RSP_FAIL,
  output logic [ULPI_DATA_W-1:0]       RSP_RDATA,
  input  logic                         READY,
  output logic                         REG_EN,
  output logic                         REG_RW,
  output logic [ULPI_ADDR_W-1:0]       REG_ADDR,
  output logic [ULPI_DATA_W-1:0]       REG_DATA_I,
  input  logic [ULPI_DATA_W-1:0]       REG_DATA_O,
  input  logic                         REG_DONE,
  input  logic                         REG_FAIL
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);

  arb_state_e             state_q, state_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d, done_q, done_d, fail_q, fail_d;
  logic [ULPI_DATA_W-1:0] rdata_q, rdata_d;
  logic                   en_q, en_d, rw_q, rw_d;
  logic [ULPI_ADDR_W-1:0] addr_q, addr_d;
  logic [ULPI_DATA_W-1:0] wdat_q, wdat_d;
  logic                   slot_rw_q, slot_rw_d;
  logic [ULPI_ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [ULPI_DATA_W-1:0] slot_data_q, slot_data_d;
  logic [IDX_W-1:0]       slot_idx_q, slot_idx_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   pick_valid, adv;
  logic [IDX_W-1:0]       pick_idx;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk_i    (CLK_60M),
    .rst_ni   (NRST_A_USB),
    .req_i    (REQ),
    .adv_i    (adv),
    .adv_idx_i(slot_idx_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  // Response pulses are set on the WAIT->RESP edge so they appear one cycle after REG_DONE/FAIL.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    fail_d      = '0;
    rdata_d     = rdata_q;
    en_d        = 1'b0;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    slot_rw_d   = slot_rw_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    slot_idx_d  = slot_idx_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    adv         = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (READY && pick_valid) begin
          slot_idx_d  = pick_idx;
          slot_rw_d   = REQ_RW[pick_idx];
          slot_addr_d = REQ_ADDR[int'(pick_idx)*ULPI_ADDR_W +: ULPI_ADDR_W];
          slot_data_d = REQ_WDATA[int'(pick_idx)*ULPI_DATA_W +: ULPI_DATA_W];
          gnt_d       = '0;
          gnt_d[pick_idx] = 1'b1;
          retry_d     = '0;
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        en_d    = 1'b1;
        rw_d    = slot_rw_q;
        addr_d  = slot_addr_q;
        wdat_d  = slot_data_q;
        tmo_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (REG_DONE) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          if (!slot_rw_q) rdata_d = REG_DATA_O;
          adv     = 1'b1;
          state_d = ARB_RESP;
        end else if (REG_FAIL || tmo_q == TMO_W'(TIMEOUT_CYC)) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ARB_RETRY;
          end else begin
            fail_d  = gnt_q;
            gnt_d   = '0;
            adv     = 1'b1;
            state_d = ARB_RESP;
          end
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ARB_RETRY: begin
        if (READY) state_d = ARB_ISSUE;
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      fail_q      <= '0;
      rdata_q     <= '0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      slot_rw_q   <= 1'b0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
      slot_idx_q  <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      rdata_q     <= rdata_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      slot_rw_q   <= slot_rw_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      slot_idx_q  <= slot_idx_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
    end
  end

  assign GNT        = gnt_q;
  assign RSP_DONE   = done_q;
  assign RSP_FAIL   = fail_q;
  assign RSP_RDATA  = rdata_q;
  assign REG_EN     = en_q;
  assign REG_RW     = rw_q;
  assign REG_ADDR   = addr_q;
  assign REG_DATA_I = wdat_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
module tb_ulpi_reg_arbiter;

  localparam int unsigned TO = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, req_rw;
  logic [17:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  gnt, rsp_done, rsp_fail;
  logic [7:0]  rsp_rdata;
  logic        ready, reg_en, reg_rw;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_data_i, reg_data_o;
  logic        reg_done, reg_fail;
  logic        core_done, core_fail, tb_done, tb_fail;

  assign reg_done = core_done | tb_done;
  assign reg_fail = core_fail | tb_fail;

  always #5 clk = ~clk;

  ulpi_reg_arbiter #(.N_REQ(3), .MAX_RETRY(3), .TIMEOUT_CYC(TO)) dut (
    .CLK_60M   (clk),
    .NRST_A_USB(rst_n),
    .REQ       (req),
    .REQ_RW    (req_rw),
    .REQ_ADDR  (req_addr),
    .REQ_WDATA (req_wdata),
    .GNT       (gnt),
    .RSP_DONE  (rsp_done),
    .RSP_FAIL  (rsp_fail),
    .RSP_RDATA (rsp_rdata),
    .READY     (ready),
    .REG_EN    (reg_en),
    .REG_RW    (reg_rw),
    .REG_ADDR  (reg_addr),
    .REG_DATA_I(reg_data_i),
    .REG_DATA_O(reg_data_o),
    .REG_DONE  (reg_done),
    .REG_FAIL  (reg_fail)
  );

  typedef struct packed {
    logic [2:0] gnt;
    logic       rw;
    logic [5:0] addr;
    logic [7:0] data;
  } iss_t;

  typedef struct packed {
    logic [2:0] done;
    logic [2:0] fail;
    logic [7:0] rdata;
  } rsp_t;

  typedef struct {
    int         idx;
    logic       rw;
    logic [5:0] addr;
    logic [7:0] wdata;
    int         nfail;
    int         dly;
    logic       both;
    logic [7:0] rdata;
    int         exp_en;
    logic       exp_fail;
  } vec_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_iss = 0;
  int n_rsp = 0;
  int last_en_cyc = 0;
  int prev_en_cyc = 0;
  int done_cyc = 0;
  logic [7:0] last_rd = 8'h00;

  // ULPI core model configuration
  int         core_nfail = 0;
  int         core_dly = 1;
  int         core_silent = 0;
  logic       core_both = 1'b0;
  logic [7:0] core_rdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ULPI core model: per transaction, attempts up to core_silent get no answer,
  // attempts up to core_nfail get REG_FAIL, later ones REG_DONE after core_dly cycles.
  initial begin
    int pend;
    int attempt;
    pend = 0;
    attempt = 0;
    core_done = 1'b0;
    core_fail = 1'b0;
    reg_data_o = 8'h00;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      core_fail = 1'b0;
      reg_data_o = 8'($urandom);
      if (!rst_n) begin
        pend = 0;
        attempt = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            if (attempt <= core_nfail) core_fail = 1'b1;
            else begin
              core_done  = 1'b1;
              core_fail  = core_both;
              reg_data_o = core_rdata;
              done_cyc   = cyc;
            end
          end
        end
        if (reg_en) begin
          attempt++;
          if (attempt > core_silent) pend = core_dly;
        end
        if (|(rsp_done | rsp_fail)) attempt = 0;
      end
    end
  end

  // Scoreboard monitor
  initial forever begin
    iss_t e;
    rsp_t r;
    @(negedge clk);
    if (rst_n) begin
      if (reg_en) begin
        n_iss++;
        prev_en_cyc = last_en_cyc;
        last_en_cyc = cyc;
        if (iss_q.size() == 0) check("unexpected_issue", 32'(1), 32'(0));
        else begin
          e = iss_q.pop_front();
          check("issue", 32'({gnt, reg_rw, reg_addr, reg_data_i}), 32'(e));
        end
      end
      if (|(rsp_done | rsp_fail)) begin
        n_rsp++;
        if (rsp_q.size() == 0) check("unexpected_rsp", 32'({rsp_done, rsp_fail}), 32'(0));
        else begin
          r = rsp_q.pop_front();
          check("rsp_kind", 32'({rsp_done, rsp_fail}), 32'({r.done, r.fail}));
          check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
          check("rsp_gnt_clear", 32'(gnt), 32'(0));
          if (|rsp_done) check("done_latency", 32'(cyc - done_cyc), 32'(1));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic expect_txn(input int idx, input logic rw, input logic [5:0] addr,
                            input logic [7:0] wdata, input int n_en, input logic fail,
                            input logic [7:0] rdata);
    logic [2:0] oh;
    oh = 3'b001 << idx;
    for (int i = 0; i < n_en; i++) iss_q.push_back('{gnt: oh, rw: rw, addr: addr, data: wdata});
    if (!rw && !fail) last_rd = rdata;
    rsp_q.push_back('{done: fail ? 3'b000 : oh, fail: fail ? oh : 3'b000, rdata: last_rd});
  endtask

  task automatic set_fields(input int idx, input logic rw, input logic [5:0] addr, input logic [7:0] wdata);
    req_rw[idx]           = rw;
    req_addr[idx*6 +: 6]  = addr;
    req_wdata[idx*8 +: 8] = wdata;
  endtask

  task automatic wait_iss(input int target, input string name);
    int b = 0;
    while (n_iss < target && b < 4000) begin
      @(negedge clk);
      b++;
    end
    if (n_iss < target) check(name, 32'(n_iss), 32'(target));
  endtask

  task automatic wait_rsp(input int target, input string name);
    int b = 0;
    while (n_rsp < target && b < 4000) begin
      @(negedge clk);
      b++;
    end
    check(name, 32'(n_rsp >= target), 32'(1));
  endtask

  initial begin
    vec_t vecs[6];
    int   base_iss, base_rsp, rc, gap;
    logic bad;

    vecs[0] = '{0, 1'b1, 6'h04, 8'h65, 0, 3, 1'b0, 8'h00, 1, 1'b0};
    vecs[1] = '{1, 1'b0, 6'h16, 8'h9C, 2, 1, 1'b0, 8'h55, 3, 1'b0};
    vecs[2] = '{2, 1'b1, 6'h0A, 8'h3C, 9, 2, 1'b0, 8'h00, 4, 1'b1};
    vecs[3] = '{0, 1'b0, 6'h04, 8'h12, 0, 1, 1'b1, 8'hA5, 1, 1'b0};
    vecs[4] = '{1, 1'b1, 6'h16, 8'h5A, 1, 5, 1'b0, 8'h00, 2, 1'b0};
    vecs[5] = '{2, 1'b0, 6'h0A, 8'h34, 3, 1, 1'b0, 8'h0F, 4, 1'b0};

    rst_n = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    ready = 1'b1; tb_done = 1'b0; tb_fail = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", 32'({gnt, rsp_done, rsp_fail, rsp_rdata}), 32'(0));
    check("reset_b", 32'({reg_en, reg_rw, reg_addr, reg_data_i}), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven single transactions: write, retry read, exhaust, DONE+FAIL, retries
    foreach (vecs[k]) begin
      core_nfail = vecs[k].nfail; core_dly = vecs[k].dly; core_both = vecs[k].both;
      core_rdata = vecs[k].rdata; core_silent = 0;
      expect_txn(vecs[k].idx, vecs[k].rw, vecs[k].addr, vecs[k].wdata,
                 vecs[k].exp_en, vecs[k].exp_fail, vecs[k].rdata);
      base_iss = n_iss; base_rsp = n_rsp;
      set_fields(vecs[k].idx, vecs[k].rw, vecs[k].addr, vecs[k].wdata);
      rc = cyc;
      req[vecs[k].idx] = 1'b1;
      wait_iss(base_iss + 1, "vec_first_issue");
      check("vec_en_latency", 32'(last_en_cyc - rc), 32'(2));
      // later field changes must not affect re-issues
      set_fields(vecs[k].idx, ~vecs[k].rw, ~vecs[k].addr, ~vecs[k].wdata);
      wait_rsp(base_rsp + 1, "vec_rsp");
      req[vecs[k].idx] = 1'b0;
      check("vec_issue_count", 32'(n_iss - base_iss), 32'(vecs[k].exp_en));
      repeat (2) @(negedge clk);
    end

    // Round-robin with all requests held
    core_nfail = 0; core_dly = 1; core_both = 1'b0;
    set_fields(0, 1'b1, 6'h04, 8'hA1);
    set_fields(1, 1'b1, 6'h0A, 8'hB2);
    set_fields(2, 1'b1, 6'h16, 8'hC3);
    expect_txn(0, 1'b1, 6'h04, 8'hA1, 1, 1'b0, 8'h00);
    expect_txn(1, 1'b1, 6'h0A, 8'hB2, 1, 1'b0, 8'h00);
    expect_txn(2, 1'b1, 6'h16, 8'hC3, 1, 1'b0, 8'h00);
    expect_txn(0, 1'b1, 6'h04, 8'hA1, 1, 1'b0, 8'h00);
    base_rsp = n_rsp;
    req = 3'b111;
    wait_rsp(base_rsp + 4, "rr_rsp");
    req = 3'b000;
    repeat (3) @(negedge clk);

    // READY low holds IDLE and RETRY
    core_nfail = 1; core_dly = 3;
    expect_txn(0, 1'b1, 6'h16, 8'h77, 2, 1'b0, 8'h00);
    base_iss = n_iss; base_rsp = n_rsp;
    ready = 1'b0;
    set_fields(0, 1'b1, 6'h16, 8'h77);
    req[0] = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (gnt != 3'b000 || reg_en) bad = 1'b1;
    end
    check("ready_low_idle", 32'(bad), 32'(0));
    ready = 1'b1; rc = cyc;
    @(negedge clk);
    check("ready_resume_gnt", 32'(gnt), 32'(3'b001));
    wait_iss(base_iss + 1, "ready_issue1");
    ready = 1'b0;
    check("ready_en_latency", 32'(last_en_cyc - rc), 32'(2));
    repeat (10) @(negedge clk);
    check("retry_hold", 32'(n_iss - base_iss), 32'(1));
    ready = 1'b1; rc = cyc;
    wait_iss(base_iss + 2, "ready_issue2");
    check("retry_resume", 32'(last_en_cyc - rc), 32'(2));
    wait_rsp(base_rsp + 1, "ready_rsp");
    req[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout: first attempt unanswered
    core_nfail = 0; core_dly = 1; core_silent = 1;
    expect_txn(1, 1'b1, 6'h04, 8'h11, 2, 1'b0, 8'h00);
    base_rsp = n_rsp;
    set_fields(1, 1'b1, 6'h04, 8'h11);
    req[1] = 1'b1;
    wait_rsp(base_rsp + 1, "timeout_rsp");
    req[1] = 1'b0;
    gap = last_en_cyc - prev_en_cyc;
    check("timeout_gap", 32'(gap >= int'(TO) + 1 && gap <= int'(TO) + 4), 32'(1));
    core_silent = 0;
    repeat (2) @(negedge clk);

    // REG_DONE/REG_FAIL outside WAIT are ignored
    base_rsp = n_rsp;
    tb_done = 1'b1; tb_fail = 1'b1;
    repeat (3) @(negedge clk);
    tb_done = 1'b0; tb_fail = 1'b0;
    repeat (3) @(negedge clk);
    check("spurious_rsp", 32'(n_rsp - base_rsp), 32'(0));
    check("spurious_gnt", 32'({gnt, reg_en}), 32'(0));

    // Reset during WAIT: silent abort, pointer back to 0
    core_silent = 99;
    base_iss = n_iss; base_rsp = n_rsp;
    iss_q.push_back('{gnt: 3'b100, rw: 1'b1, addr: 6'h0A, data: 8'h5E});
    set_fields(2, 1'b1, 6'h0A, 8'h5E);
    req[2] = 1'b1;
    wait_iss(base_iss + 1, "reset_issue");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_a", 32'({gnt, rsp_done, rsp_fail, rsp_rdata}), 32'(0));
    check("midreset_b", 32'({reg_en, reg_rw, reg_addr, reg_data_i}), 32'(0));
    req = 3'b000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_rd = 8'h00;
    repeat (20) @(negedge clk);
    check("midreset_no_rsp", 32'(n_rsp - base_rsp), 32'(0));
    core_silent = 0;
    set_fields(0, 1'b1, 6'h04, 8'hD0);
    set_fields(1, 1'b1, 6'h0A, 8'hD1);
    set_fields(2, 1'b1, 6'h16, 8'hD2);
    expect_txn(0, 1'b1, 6'h04, 8'hD0, 1, 1'b0, 8'h00);
    req = 3'b111;
    wait_rsp(base_rsp + 1, "post_reset_rsp");
    req = 3'b000;
    repeat (4) @(negedge clk);

    check("iss_queue_empty", 32'(iss_q.size()), 32'(0));
    check("rsp_queue_empty", 32'(rsp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
